// File: rtl/iter_divider_pkg.sv
// iter_divider_pkg
//   Shared definitions for the iterative divider slice:
//   - DIV_WIDTH       default operand width
//   - ALUOP_DIV/DIVU  ALU operation encodings; decode maps DIV -> start with
//                     is_signed=1 and DIVU -> start with is_signed=0
//   - div_state_e     divider FSM state encoding (IDLE, PREP, ITER, FIX)
package iter_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic [5:0] ALUOP_DIV  = 6'h1A;
    localparam logic [5:0] ALUOP_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } div_state_e;

    function automatic logic aluop_is_div(input logic [5:0] op);
        return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
    endfunction

    function automatic logic aluop_div_signed(input logic [5:0] op);
        return op == ALUOP_DIV;
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// iter_divider_if
//   Request/response bundle between the execute stage and the divider.
//   master (pipeline): drives start, is_signed, A, B; receives busy, done,
//                      divzero, result
//   slave  (divider) : the reverse
interface iter_divider_if
    import iter_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic                 divzero;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, is_signed, A, B,
        input  busy, done, divzero, result
    );

    modport slave (
        input  start, is_signed, A, B,
        output busy, done, divzero, result
    );
endinterface

// File: rtl/iter_divider_div_step.sv
// div_step
//   One restoring division iteration (combinational).
//   rem      : partial remainder (always < divisor)
//   quo      : dividend bits still to shift in / quotient bits built so far
//   divisor  : divisor magnitude
//   rem_nxt  : partial remainder after this iteration
//   quo_nxt  : quotient register after this iteration
module div_step
    import iter_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The shifted remainder can reach 2*divisor-1, so the trial subtract
    // needs one extra bit to stay correct for full-range unsigned divisors.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/iter_divider.sv
// iter_divider
//   Multi-cycle signed/unsigned restoring divider, one iteration per clock.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset; discards any in-flight division
//   bus    : iter_divider_if.slave
//            start/is_signed/A/B sampled only while idle;
//            busy high PREP..FIX; done one-cycle pulse in the first idle
//            cycle after FIX; result = {quotient, remainder}, held until the
//            next FIX; divzero valid with done
//   Build option DIV_ZERO_DETECT_EN: a zero divisor skips the iterations and
//   flags divzero. Without it divzero is tied low and B==0 runs full length.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    iter_divider_if.slave  bus
);
    localparam int unsigned     CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

    div_state_e             state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic                   signed_q, signed_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic                   done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
    logic                   divzero_q, divzero_d;
`endif

    logic [WIDTH-1:0]       rem_nxt;
    logic [WIDTH-1:0]       quo_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (b_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        signed_d  = signed_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        divzero_d = divzero_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    signed_d = bus.is_signed;
                    state_d  = ST_PREP;
`ifdef DIV_ZERO_DETECT_EN
                    divzero_d = 1'b0;
`endif
                end
            end

            ST_PREP: begin
                // a_q is kept raw for the divide-by-zero result; the
                // magnitude of A starts life in the quotient register and
                // b_q is overwritten with |B|.
                quo_d     = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
                b_d       = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
                neg_quo_d = signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = signed_q & a_q[WIDTH-1];
                rem_d     = '0;
                cnt_d     = '0;
                state_d   = ST_ITER;
`ifdef DIV_ZERO_DETECT_EN
                if (b_q == '0) begin
                    state_d = ST_FIX;
                end
`endif
            end

            ST_ITER: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                result_d = {neg_quo_q ? -quo_q : quo_q,
                            neg_rem_q ? -rem_q : rem_q};
                done_d   = 1'b1;
                state_d  = ST_IDLE;
`ifdef DIV_ZERO_DETECT_EN
                if (b_q == '0) begin
                    result_d  = {{WIDTH{1'b1}}, a_q};
                    divzero_d = 1'b1;
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            divzero_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            signed_q  <= signed_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
`ifdef DIV_ZERO_DETECT_EN
            divzero_q <= divzero_d;
`endif
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.divzero = divzero_q;
`else
    assign bus.divzero = 1'b0;
`endif

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;
    import iter_divider_pkg::*;

`ifdef DIV_ZERO_DETECT_EN
    localparam int   DZ_LAT  = 2;
    localparam logic DZ_FLAG = 1'b1;
`else
    localparam int   DZ_LAT  = 34;
    localparam logic DZ_FLAG = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    iter_divider_if #(.WIDTH(32)) bus ();

    iter_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a start pulse sampled by the next rising edge; returns 1 time
    // unit after that edge with start deasserted.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.A         = a;
        bus.B         = b;
        bus.is_signed = s;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
    endtask

    // Count rising edges from the start-sampling edge until done is seen.
    // lat = -1 when the bound expires; gaps counts pre-done cycles with busy low.
    task automatic wait_done(output int lat, output int gaps);
        lat  = -1;
        gaps = 0;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.busy !== 1'b1) gaps++;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", bus.done); end
        vectors++;
        if (bus.divzero !== 1'b0) begin miscompares++; $display("FAIL reset divzero: got %b want 0", bus.divzero); end
        vectors++;
        if (bus.result !== 64'h0) begin miscompares++; $display("FAIL reset result: got %h want 0", bus.result); end
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [31:0] va [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vb [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                32'd1, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic        vs [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] ve [7] = '{64'h0000000E_00000002, 64'hFFFFFFFD_FFFFFFFF,
                                64'hFFFFFFFD_00000001, 64'h80000000_00000000,
                                64'hFFFFFFFF_00000000, 64'h00000001_00000001,
                                64'h00000000_FFFFFFFF};
        int lat, gaps;
        for (int i = 0; i < 7; i++) begin
            issue(va[i], vb[i], vs[i]);
            wait_done(lat, gaps);
            vectors++;
            if (lat != 34) begin miscompares++; $display("FAIL arith[%0d] latency: got %0d want 34", i, lat); end
            vectors++;
            if (gaps != 0) begin miscompares++; $display("FAIL arith[%0d] busy gaps: got %0d want 0", i, gaps); end
            vectors++;
            if (bus.result !== ve[i]) begin miscompares++; $display("FAIL arith[%0d] result: got %h want %h", i, bus.result, ve[i]); end
            vectors++;
            if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL arith[%0d] busy at done: got %b want 0", i, bus.busy); end
            vectors++;
            if (bus.divzero !== 1'b0) begin miscompares++; $display("FAIL arith[%0d] divzero: got %b want 0", i, bus.divzero); end
            @(posedge clk);
            #1;
            vectors++;
            if (bus.done !== 1'b0) begin miscompares++; $display("FAIL arith[%0d] done width: got %b want 0", i, bus.done); end
        end
    endtask

    task automatic test_divzero();
        int lat, gaps;
        logic [63:0] exp_neg;
`ifdef DIV_ZERO_DETECT_EN
        exp_neg = 64'hFFFFFFFF_FFFFFFFB;
`else
        exp_neg = 64'h00000001_FFFFFFFB;
`endif
        issue(32'd5, 32'd0, 1'b0);
        wait_done(lat, gaps);
        vectors++;
        if (lat != DZ_LAT) begin miscompares++; $display("FAIL divzero_u latency: got %0d want %0d", lat, DZ_LAT); end
        vectors++;
        if (bus.divzero !== DZ_FLAG) begin miscompares++; $display("FAIL divzero_u flag: got %b want %b", bus.divzero, DZ_FLAG); end
        vectors++;
        if (bus.result !== 64'hFFFFFFFF_00000005) begin miscompares++; $display("FAIL divzero_u result: got %h want FFFFFFFF00000005", bus.result); end

        issue(32'hFFFFFFFB, 32'd0, 1'b1);
        wait_done(lat, gaps);
        vectors++;
        if (lat != DZ_LAT) begin miscompares++; $display("FAIL divzero_s latency: got %0d want %0d", lat, DZ_LAT); end
        vectors++;
        if (bus.result !== exp_neg) begin miscompares++; $display("FAIL divzero_s result: got %h want %h", bus.result, exp_neg); end

        // flag must drop once a normal division is accepted
        issue(32'd9, 32'd3, 1'b0);
        vectors++;
        if (bus.divzero !== 1'b0) begin miscompares++; $display("FAIL divzero clear: got %b want 0", bus.divzero); end
        wait_done(lat, gaps);
        vectors++;
        if (bus.result !== 64'h00000003_00000000) begin miscompares++; $display("FAIL divzero follow result: got %h want 0000000300000000", bus.result); end
    endtask

    task automatic test_ignore_start();
        int lat;
        issue(32'd100, 32'd7, 1'b0);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) begin
                bus.start     = 1'b1;
                bus.A         = 32'd55;
                bus.B         = 32'd5;
                bus.is_signed = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat != 34) begin miscompares++; $display("FAIL ignore latency: got %0d want 34", lat); end
        vectors++;
        if (bus.result !== 64'h0000000E_00000002) begin miscompares++; $display("FAIL ignore result: got %h want 0000000E00000002", bus.result); end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ignore restart: busy got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int lat, gaps;
        issue(32'd100, 32'd7, 1'b0);
        wait_done(lat, gaps);
        vectors++;
        if (bus.result !== 64'h0000000E_00000002) begin miscompares++; $display("FAIL b2b first result: got %h want 0000000E00000002", bus.result); end
        // issue in the done cycle itself
        bus.start     = 1'b1;
        bus.A         = 32'd1000;
        bus.B         = 32'd10;
        bus.is_signed = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b accept busy: got %b want 1", bus.busy); end
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (bus.result !== 64'h0000000E_00000002) begin miscompares++; $display("FAIL b2b held result: got %h want 0000000E00000002", bus.result); end
        lat = -1;
        for (int k = 11; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat != 34) begin miscompares++; $display("FAIL b2b second latency: got %0d want 34", lat); end
        vectors++;
        if (bus.result !== 64'h00000064_00000000) begin miscompares++; $display("FAIL b2b second result: got %h want 0000006400000000", bus.result); end
    endtask

    task automatic test_reset_mid();
        int lat, gaps, pulses;
        issue(32'd100, 32'd7, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midreset busy: got %b want 0", bus.busy); end
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midreset done: got %b want 0", bus.done); end
        vectors++;
        if (bus.result !== 64'h0) begin miscompares++; $display("FAIL midreset result: got %h want 0", bus.result); end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL midreset ghost activity: got %0d want 0", pulses); end
        issue(32'd9, 32'd3, 1'b0);
        wait_done(lat, gaps);
        vectors++;
        if (lat != 34) begin miscompares++; $display("FAIL midreset follow latency: got %0d want 34", lat); end
        vectors++;
        if (bus.result !== 64'h00000003_00000000) begin miscompares++; $display("FAIL midreset follow result: got %h want 0000000300000000", bus.result); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_arith();
        test_divzero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
